// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_target_calc.sv
// Branch resolution: computes the taken flag, the word-aligned target and
// whether the raw target sum was misaligned.
module pc_target_calc #(
  parameter int XLEN = 32
) (
  input  logic            i_branch,
  input  logic            i_zero,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_imm_shifted,
  output logic            o_take,
  output logic [XLEN-1:0] o_target,
  output logic            o_misalign
);

  logic [XLEN-1:0] w_sum;

  assign w_sum      = i_ex_pc + i_imm_shifted;
  assign o_take     = i_branch & i_zero;
  assign o_target   = {w_sum[XLEN-1:2], 2'b00};
  assign o_misalign = o_take & (|w_sum[1:0]);

endmodule

// File: rtl/pc_fetch_unit.sv
// Registered, stall-aware fetch engine: one outstanding imem request at a
// time, instruction held for decode until accepted, branch redirect kills wrong-path work.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm_shifted,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            misalign_err
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_inflight;
  logic            r_kill;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_instr;
  logic [XLEN-1:0] r_if_pc;
  logic            r_misalign_err;

  logic            w_take;
  logic [XLEN-1:0] w_target;
  logic            w_misalign;

  pc_target_calc #(.XLEN(XLEN)) u_target (
    .i_branch      (branch),
    .i_zero        (zero),
    .i_ex_pc       (ex_pc),
    .i_imm_shifted (imm_shifted),
    .o_take        (w_take),
    .o_target      (w_target),
    .o_misalign    (w_misalign)
  );

  // A redirect cycle never issues a request, so the old pc is never fetched.
  assign imem_req_valid = (r_state == S_REQ) & ~stall & ~reset & ~w_take;
  assign imem_addr      = r_pc;
  assign if_valid       = r_if_valid;
  assign if_instr       = r_if_instr;
  assign if_pc          = r_if_pc;
  assign misalign_err   = r_misalign_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_REQ;
      r_pc           <= RESET_PC;
      r_pc_inflight  <= '0;
      r_kill         <= 1'b0;
      r_if_valid     <= 1'b0;
      r_if_instr     <= '0;
      r_if_pc        <= '0;
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= w_misalign;
      // NOTE: the redirect branch comes first so it outranks stall, response and if_ready.
      if (w_take) begin
        r_pc <= w_target;
        case (r_state)
          S_WAIT: begin
            if (imem_rsp_valid) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_kill  <= 1'b1;
            end
          end
          S_HOLD: begin
            r_if_valid <= 1'b0;
            r_state    <= S_REQ;
          end
          default: r_state <= S_REQ;
        endcase
      end else begin
        case (r_state)
          S_REQ: begin
            if (imem_req_valid && imem_req_ready) begin
              r_pc_inflight <= r_pc;
              r_state       <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              if (r_kill) begin
                r_kill  <= 1'b0;
                r_state <= S_REQ;
              end else begin
                r_if_instr <= imem_rsp_data;
                r_if_pc    <= r_pc_inflight;
                r_if_valid <= 1'b1;
                r_pc       <= r_pc + XLEN'(PC_INC);
                r_state    <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (if_ready) begin
              r_if_valid <= 1'b0;
              r_state    <= S_REQ;
            end
          end
          default: r_state <= S_REQ;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  a_rsp_only_in_wait: assert property (
    @(posedge clk) disable iff (reset) imem_rsp_valid |-> (r_state == S_WAIT)
  );
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and issues instruction fetches to instruction memory through a valid/ready request and response interface.
- Presents each fetched instruction and its PC to the decode stage through a valid/ready handshake.
- Consumes the branch decision from EX (branch AND zero) and redirects fetch to the branch target, discarding wrong-path work.
- Sits at the front of the datapath and replaces the free-running PC-next selection with a registered, stall-aware fetch engine.

Parameters:
- XLEN, 32: PC, address and instruction width.
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- stall, input, 1: hazard stall; suppresses new fetch requests.
- branch, input, 1: EX-stage instruction is a conditional branch.
- zero, input, 1: ALU zero flag of that EX-stage instruction.
- ex_pc, input, XLEN: PC of the EX-stage instruction.
- imm_shifted, input, XLEN: branch offset, already sign-extended and shifted left by 1.
- imem_req_valid, output, 1: fetch request valid.
- imem_req_ready, input, 1: memory accepts the request.
- imem_addr, output, XLEN: fetch address, equal to pc.
- imem_rsp_valid, input, 1: instruction returned; a single-cycle pulse.
- imem_rsp_data, input, XLEN: returned instruction.
- if_valid, output, 1: if_instr and if_pc are valid.
- if_ready, input, 1: decode accepts the instruction.
- if_instr, output, XLEN: fetched instruction.
- if_pc, output, XLEN: PC of if_instr.
- misalign_err, output, 1: one-cycle pulse when a taken target has bit1 or bit0 set.

Behaviour:
- Reset (synchronous) sets:
  - pc = RESET_PC, state = S_REQ, kill = 0.
  - if_valid = 0, if_instr = 0, if_pc = 0, misalign_err = 0.
  - imem_req_valid = 0 while reset is high.
- imem_req_valid = (state == S_REQ) & ~stall & ~reset & ~take. Combinational; no request is issued in a redirect cycle.
- take = branch & zero, sampled each cycle.
- target = (ex_pc + imm_shifted) mod 2^XLEN, with bits [1:0] forced to 0. misalign_err pulses in the cycle after take if the raw sum has bits [1:0] != 0.
- S_REQ:
  - On req_valid & req_ready: capture pc_inflight = pc and go to S_WAIT.
  - With stall high: hold state and pc.
- S_WAIT, on imem_rsp_valid:
  - If kill = 1: discard the response, clear kill, go to S_REQ.
  - Otherwise: if_instr = rsp_data, if_pc = pc_inflight, if_valid = 1, pc = pc + 4 (wraps at 2^XLEN), go to S_HOLD.
- S_HOLD: on if_ready, set if_valid = 0 and go to S_REQ. stall does not affect S_WAIT or S_HOLD.
- Latency: request accepted at edge N, response at N+k, if_valid high from N+k+1. Minimum fetch-to-fetch interval is 3 cycles; no overlap.
- Redirect (take = 1) has priority over stall, response and if_ready:
  - All states: pc = target at the edge.
  - S_REQ: no request is issued in the take cycle; the next cycle requests target (unless stalled).
  - S_WAIT, no response this cycle: kill = 1, stay in S_WAIT.
  - S_WAIT, response this cycle: drop it, kill = 0, go to S_REQ.
  - S_HOLD: if_valid = 0 regardless of if_ready, go to S_REQ.
- Back-to-back takes: the last one wins, and kill remains set.
- Reset mid-operation: returns to the reset state; any outstanding response is ignored.
- Responses that arrive in S_REQ or S_HOLD are protocol violations. They are ignored and a simulation assertion fires.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum {S_REQ, S_WAIT, S_HOLD};
  - constants PC_INC = 4 and DEFAULT_RESET_PC.
- One natural sub-module: pc_target_calc (combinational). It computes target, take and the misalign flag from branch, zero, ex_pc and imm_shifted.

Test Plan:
- Reset release with RESET_PC = 0, req_ready = 1, 1-cycle memory, if_ready = 1 -> imem_addr sequence 0, 4, 8. if_pc matches each address, one instruction per 3 cycles.
- Hold if_ready = 0 for 5 cycles with instruction 32'h00500093 at pc 0 -> if_valid and if_instr stay stable. The next request (addr 4) is issued only after if_ready rises.
- stall = 1 in S_REQ for 4 cycles at pc = 8 -> imem_req_valid = 0 throughout, pc stays 8. Request with addr 8 follows stall release.
- branch = 1, zero = 1, ex_pc = 0x10, imm_shifted = 0xFFFFFFF8, pulsed while in S_WAIT for addr 0x18 -> response discarded, next request addr 0x08, no if_valid for the 0x18 data.
- branch = 1, zero = 0 -> no redirect, sequential fetch continues. ex_pc = 0xFFFFFFFC with imm_shifted = 8 -> target wraps to 0x4.
- imm_shifted = 0x6 with ex_pc = 0x0 -> misalign_err pulses 1 cycle, next fetch addr 0x4.
